// File: rtl/dtw_result_filter.sv
// dtw_result_filter: drains 3-word DTW result records (qid, position, cost) from the
// core's sink FIFO. It classifies each record against a cost threshold and can drop
// non-matching records. Surviving records are re-emitted as 3-beat AXI-Stream packets.
// Running record and accept counters are kept for the driver.
module dtw_result_filter #(
    parameter int unsigned AXIS_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  filter_en,
    input  logic [15:0]           threshold,
    input  logic                  stats_clr,
    output logic                  fifo_rden,
    input  logic                  fifo_empty,
    input  logic [31:0]           fifo_data,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [CNT_WIDTH-1:0]  rec_count,
    output logic [CNT_WIDTH-1:0]  acc_count,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        StFetch  = 2'd0,
        StDecide = 2'd1,
        StEmit   = 2'd2
    } state_e;

    state_e                state_q;
    logic [1:0]            issued_q;
    logic [1:0]            captured_q;
    logic                  rd_pending_q;
    logic [1:0]            beat_q;
    logic [31:0]           qid_q;
    logic [31:0]           pos_q;
    logic [15:0]           cost_q;
    logic                  match_q;
    logic [AXIS_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic [CNT_WIDTH-1:0]  rec_q;
    logic [CNT_WIDTH-1:0]  acc_q;
    logic                  match_d;

    // FIFO read request and the threshold comparison used in DECIDE.
    always_comb begin
        fifo_rden = !rst && (state_q == StFetch) && !fifo_empty && (issued_q != 2'd3);
        match_d   = (cost_q <= threshold);
    end

    // Record FSM: fetch 3 words, classify, then stream the beats out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFetch;
            issued_q     <= 2'd0;
            captured_q   <= 2'd0;
            rd_pending_q <= 1'b0;
            beat_q       <= 2'd0;
            qid_q        <= 32'd0;
            pos_q        <= 32'd0;
            cost_q       <= 16'd0;
            match_q      <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
        end else begin
            // FIFO read data arrives one cycle after the request.
            rd_pending_q <= fifo_rden;
            unique case (state_q)
                StFetch: begin
                    if (fifo_rden) begin
                        issued_q <= issued_q + 2'd1;
                    end
                    if (rd_pending_q) begin
                        case (captured_q)
                            2'd0:    qid_q  <= fifo_data;
                            2'd1:    pos_q  <= fifo_data;
                            default: cost_q <= fifo_data[15:0];
                        endcase
                        if (captured_q == 2'd2) begin
                            captured_q <= 2'd0;
                            issued_q   <= 2'd0;
                            state_q    <= StDecide;
                        end else begin
                            captured_q <= captured_q + 2'd1;
                        end
                    end
                end
                StDecide: begin
                    match_q <= match_d;
                    if (filter_en && !match_d) begin
                        state_q <= StFetch;
                    end else begin
                        state_q  <= StEmit;
                        beat_q   <= 2'd0;
                        tvalid_q <= 1'b1;
                        tdata_q  <= qid_q;
                        tlast_q  <= 1'b0;
                    end
                end
                StEmit: begin
                    if (tvalid_q && m_axis_tready) begin
                        case (beat_q)
                            2'd0: begin
                                tdata_q <= pos_q;
                                beat_q  <= 2'd1;
                            end
                            2'd1: begin
                                tdata_q <= {match_q, 15'b0, cost_q};
                                tlast_q <= 1'b1;
                                beat_q  <= 2'd2;
                            end
                            default: begin
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                                beat_q   <= 2'd0;
                                state_q  <= StFetch;
                            end
                        endcase
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    // Statistics counters; a clear overrides a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            rec_q <= '0;
            acc_q <= '0;
        end else if (state_q == StDecide) begin
            rec_q <= rec_q + 1'b1;
            acc_q <= acc_q + {{(CNT_WIDTH-1){1'b0}}, match_d};
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign rec_count     = rec_q;
    assign acc_count     = acc_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dtw_result_filter.sv
// Scoreboard bench for dtw_result_filter: a FIFO model feeds records, expected beats
// are queued when a record is issued, and a monitor checks every transferred beat.
module tb_dtw_result_filter;

    // Narrow counters so that random traffic wraps them.
    localparam int unsigned CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          filter_en;
    logic [15:0]   threshold;
    logic          stats_clr;
    logic          fifo_rden;
    logic          fifo_empty = 1'b1;
    logic [31:0]   fifo_data = 32'd0;
    logic [31:0]   tdata;
    logic          tvalid;
    logic          tready = 1'b1;
    logic          tlast;
    logic [CW-1:0] rec_count;
    logic [CW-1:0] acc_count;
    logic [1:0]    dbg_state;

    dtw_result_filter #(
        .AXIS_WIDTH(32),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .filter_en    (filter_en),
        .threshold    (threshold),
        .stats_clr    (stats_clr),
        .fifo_rden    (fifo_rden),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast (tlast),
        .rec_count    (rec_count),
        .acc_count    (acc_count),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic [31:0]   fifo_q[$];
    beat_t         exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            decides = 0;
    int            rec_issued = 0;
    int            cyc = 0;
    int            last_pop_cyc = 0;
    int            tr_mode = 0;
    logic [CW-1:0] rec_m = '0;
    logic [CW-1:0] acc_m = '0;
    logic          prev_stall = 1'b0;
    logic [31:0]   prev_data = 32'd0;
    logic          prev_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Sink FIFO model: read data appears the cycle after rden.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rden && fifo_q.size() > 0) begin
            fifo_data    <= fifo_q.pop_front();
            last_pop_cyc <= cyc;
        end
    end

    always @(negedge clk) begin
        #1;
        fifo_empty = (fifo_q.size() == 0);
    end

    // Downstream ready: 0 = always ready, 1 = toggling, 2 = random.
    always @(posedge clk) begin
        #1;
        case (tr_mode)
            0:       tready = 1'b1;
            1:       tready = !tready;
            default: tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compare transferred beats and AXI-Stream hold rules.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (dbg_state == 2'd1) decides++;
            if (fifo_rden) check("rden_only_in_fetch", {30'd0, dbg_state}, 32'd0);
            if (prev_stall) begin
                check("stall_valid_held", {31'd0, tvalid}, 32'd1);
                check("stall_data_held", tdata, prev_data);
                check("stall_last_held", {31'd0, tlast}, {31'd0, prev_last});
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%08h, expected no beat", tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", tdata, e.data);
                    check("beat_last", {31'd0, tlast}, {31'd0, e.last});
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    // Queue a record into the FIFO (words from index skip on) and predict its outcome.
    task automatic issue_rec(input logic [31:0] q, input logic [31:0] p, input logic [31:0] c,
                             input int skip);
        logic [31:0] w[3];
        logic [15:0] cl;
        logic        m;
        w[0] = q;
        w[1] = p;
        w[2] = c;
        cl   = c[15:0];
        m    = (cl <= threshold);
        rec_m = rec_m + 1'b1;
        if (m) acc_m = acc_m + 1'b1;
        if (!filter_en || m) begin
            exp_q.push_back('{data: q, last: 1'b0});
            exp_q.push_back('{data: p, last: 1'b0});
            exp_q.push_back('{data: {m, 15'd0, cl}, last: 1'b1});
        end
        for (int i = skip; i < 3; i++) fifo_q.push_back(w[i]);
        rec_issued++;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(decides == rec_issued && exp_q.size() == 0 && dbg_state == 2'd0 &&
                 fifo_q.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d beats pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        check({name, "_rec_count"}, {27'd0, rec_count}, {27'd0, rec_m});
        check({name, "_acc_count"}, {27'd0, acc_count}, {27'd0, acc_m});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [15:0] hi;
        logic [15:0] lo;
        rst       = 1'b1;
        filter_en = 1'b0;
        threshold = 16'd0;
        stats_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rden", {31'd0, fifo_rden}, 32'd0);
        check("reset_tvalid", {31'd0, tvalid}, 32'd0);
        check("reset_tlast", {31'd0, tlast}, 32'd0);
        check("reset_tdata", tdata, 32'd0);
        check("reset_rec", {27'd0, rec_count}, 32'd0);
        check("reset_acc", {27'd0, acc_count}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single passed record plus output latency.
        threshold = 16'd100;
        issue_rec(32'd7, 32'd1234, 32'd150, 0);
        n = 0;
        while (!tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("beat0_latency", 32'(cyc - last_pop_cyc), 32'd3);
        wait_done("single");

        // Filtering: inclusive threshold passes, one above is dropped.
        filter_en = 1'b1;
        issue_rec(32'd1, 32'd10, 32'd100, 0);
        wait_done("filter_pass");
        issue_rec(32'd2, 32'd20, 32'd101, 0);
        wait_done("filter_drop");

        // Toggling ready, two records back to back in the FIFO.
        filter_en = 1'b0;
        tr_mode   = 1;
        issue_rec(32'd3, 32'd30, 32'd5, 0);
        issue_rec(32'd13, 32'd31, 32'hFFFF_0006, 0);
        wait_done("stall");
        tr_mode = 0;

        // FIFO runs dry after the first word.
        fifo_q.push_back(32'd4);
        repeat (10) @(negedge clk);
        check("empty_rden_low", {31'd0, fifo_rden}, 32'd0);
        check("empty_state_fetch", {30'd0, dbg_state}, 32'd0);
        issue_rec(32'd4, 32'd40, 32'd9, 1);
        wait_done("refill");

        // Clear coinciding with DECIDE.
        issue_rec(32'd5, 32'd50, 32'd7, 0);
        n = 0;
        while (dbg_state != 2'd1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        rec_m = '0;
        acc_m = '0;
        check("clr_rec", {27'd0, rec_count}, 32'd0);
        check("clr_acc", {27'd0, acc_count}, 32'd0);
        wait_done("clr");

        // Reset with two words captured.
        issue_rec(32'd6, 32'd60, 32'd1, 0);
        wait_done("pre_reset");
        fifo_q.push_back(32'd70);
        fifo_q.push_back(32'd700);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rec_m = '0;
        acc_m = '0;
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_rec", {27'd0, rec_count}, 32'd0);
        check("rst_acc", {27'd0, acc_count}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        issue_rec(32'd8, 32'd80, 32'd3, 0);
        wait_done("post_reset");

        // Random traffic; enough records to wrap the counters.
        tr_mode = 2;
        for (int i = 0; i < 45; i++) begin
            filter_en = 1'($urandom_range(0, 1));
            threshold = 16'($urandom_range(0, 300));
            hi = 16'($urandom);
            lo = (($urandom_range(0, 3)) == 0) ? threshold : 16'($urandom_range(0, 300));
            issue_rec($urandom, $urandom, {hi, lo}, 0);
            wait_done("random");
        end

        check("no_leftover_beats", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
